bcd_to_bin: RTL
===============

Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter (reverse double dabble); the inverse of the binary-to-BCD path used by the HUD number renderer.
- Takes packed decimal digits and returns their binary value for game logic, e.g. lap count, speed limit or score entered digit-by-digit in menus.
- Processes one bit per pclk cycle, with a start/busy/done handshake.

Parameters:
- DIGITS, 3, number of packed BCD digits on bcd_in.
- BIN_W, 10, width of bin_out. Must satisfy 2^BIN_W > 10^DIGITS-1 and BIN_W <= 4*DIGITS.

Ports:
- pclk  input  1  system pixel clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- bcd_in  input  4*DIGITS  packed digits, most significant digit in the MSBs; sampled on accepted start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_out is updated.
- bin_out  output  BIN_W  converted value; held until the next done.
- err  output  1  invalid-digit flag (see Optional Feature); valid alongside done, then held.

Behaviour:
- Interface: one clock (pclk); reset is synchronous and active-low (rst_n).
- States: IDLE, SHIFT, DONE.
- Reset (rst_n=0 at a pclk edge): state=IDLE; busy=0, done=0, bin_out=0, err=0; internal registers cleared. Applies in any state; a conversion interrupted by reset never produces done.
- IDLE, start=1: load bcd_in into the digit register D (4*DIGITS bits) and clear the result register R (4*DIGITS bits). Load counter N=4*DIGITS, go to SHIFT. busy=1 from the next cycle.
- SHIFT, each cycle:
  - Shift {D,R} right by 1 as one concatenation (LSB of D enters MSB of R).
  - On the shifted D, subtract 3 from every 4-bit digit whose value is >=8. All digits are corrected in parallel, in the same cycle.
  - Decrement N. When N reaches 0, go to DONE.
- DONE (one cycle): bin_out <= R[BIN_W-1:0]; done=1; busy=0; next state IDLE.
- Latency: start accepted at edge k; done=1 and bin_out valid during the cycle after edge k+4*DIGITS+1, i.e. 13 cycles for DIGITS=3.
- start while busy=1: ignored, no queuing.
- start asserted during the DONE cycle: ignored. The request must be held or re-asserted in IDLE. Back-to-back throughput is therefore one conversion per 4*DIGITS+2 cycles.
- bcd_in changes after acceptance do not affect the conversion in progress.
- Widths: all digit arithmetic is 4-bit, modulo 16. With valid input no digit underflows. R bits above BIN_W are discarded; they are always 0 for valid input.
- Invalid digits (>9) without the optional feature: the algorithm runs unchanged and the result is deterministic but meaningless; err stays 0.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - On accepted start, latch a flag = OR over all digits of (digit > 9).
  - err is updated with this flag at done and held until the next done or reset.
  - The conversion still completes, with the same latency.
- Undefined: err is tied to 0 and there is no comparison logic.

Decomposition:
- Shared package/header:
  - Defaults for DIGITS and BIN_W.
  - BCD digit width constant (4).
  - Correction threshold (8) and correction value (3).
  - State encodings for IDLE, SHIFT, DONE.
- Sub-module bcd_digit_adj: 4-bit combinational correction (if >=8 then -3). Instantiated DIGITS times in a generate loop inside the SHIFT datapath.
- FSM, counter and registers stay in the top module.

Test Plan:
- Reset, then start with bcd_in=12'h000 -> after 13 cycles done=1, bin_out=0, err=0; busy high for exactly 12 cycles.
- bcd_in=12'h255 -> bin_out=10'd255 (0x0FF). Then bcd_in=12'h999 -> bin_out=10'd999 (0x3E7).
- Start with 12'h128, then pulse start with 12'h777 at cycle 5 -> single done, bin_out=128; the second request is ignored.
- Start with 12'h456, assert rst_n=0 at cycle 6 for one cycle -> busy=0, bin_out=0, no done pulse; a new start with 12'h042 -> bin_out=42.
- Exhaustive sweep 000..999, each started on the first IDLE cycle -> bin_out equals the decimal value, and done spacing is 14 cycles.
- BCD_DIGIT_CHECK_EN defined: bcd_in=12'h1A3 -> err=1 with done; next conversion 12'h013 -> err=0, bin_out=13. With the macro undefined, err stays 0 for 12'h1A3.

Source files
------------

// File: rtl/bcd_to_bin_pkg.sv
// Shared constants for the BCD-to-binary converter: default sizing, digit
// arithmetic constants and FSM state encodings.
// Pure declarations, no logic, no latency, no flow control.
package bcd_to_bin_pkg;

    // Default sizing: three packed decimal digits -> 10-bit binary (0..999)
    localparam int DIGITS_DEF = 3;
    localparam int BIN_W_DEF  = 10;

    // One packed BCD digit
    localparam int BCD_W = 4;

    // Reverse double dabble correction: digits >= 8 after a right shift get -3
    localparam logic [BCD_W-1:0] ADJ_THRESH = 4'd8;
    localparam logic [BCD_W-1:0] ADJ_VAL    = 4'd3;

    // Largest legal decimal digit
    localparam logic [BCD_W-1:0] BCD_MAX    = 4'd9;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bcd_to_bin_digit_adj.sv
// Single-digit correction for reverse double dabble: subtract 3 when digit >= 8.
// Purely combinational, zero latency.
// No handshake; evaluated every cycle by the parent datapath.
module bcd_digit_adj
    import bcd_to_bin_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    // Modulo-16 correction; valid BCD input never underflows here
    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din - ADJ_VAL;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble), one bit per pclk.
// Latency: done pulses 4*DIGITS+1 cycles after the accepting edge (13 for DIGITS=3).
// Backpressure: start is ignored while busy and during the DONE cycle; no queuing.
// Optional invalid-digit flag on err when BCD_DIGIT_CHECK_EN is defined.
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int DW    = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(DW + 1);

    logic [1:0]       state_q;
    logic [DW-1:0]    d_q;      // remaining decimal digits being drained
    logic [DW-1:0]    r_q;      // binary result collected from the right
    logic [CNT_W-1:0] cnt_q;    // shifts still to perform

    logic [DW-1:0]    d_sh;
    logic [DW-1:0]    r_sh;
    logic [DW-1:0]    d_adj;
    logic [CNT_W-1:0] cnt_dec;

    // The digit/result pair shifts as one word: D's LSB becomes R's MSB
    always_comb begin
        {d_sh, r_sh} = {d_q, r_q} >> 1;
        cnt_dec      = cnt_q - CNT_W'(1);
    end

    // Every digit of the shifted D is corrected in parallel in the same cycle
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (d_sh [g*BCD_W +: BCD_W]),
            .dout (d_adj[g*BCD_W +: BCD_W])
        );
    end

    // Control FSM, shift counter and datapath registers
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        d_q     <= bcd_in;
                        r_q     <= '0;
                        cnt_q   <= CNT_W'(DW);
                        busy    <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    d_q   <= d_adj;
                    r_q   <= r_sh;
                    cnt_q <= cnt_dec;
                    if (cnt_dec == '0) begin
                        busy    <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Bits of R above BIN_W are always zero for legal input
                    bin_out <= r_q[BIN_W-1:0];
                    done    <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic bad_digit;
    logic bad_q;

    // Any digit above 9 on the incoming word marks the request as invalid
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*BCD_W +: BCD_W] > BCD_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Flag is captured at acceptance and published together with done
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                bad_q <= bad_digit;
            end
            if (state_q == ST_DONE) begin
                err <= bad_q;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
